// File: rtl/scene_drawer.sv
// -----------------------------------------------------------------------------
// scene_drawer
//   Repaints the frame through the VGA adapter pixel port whenever navigation
//   signals a transition. A repaint floods the whole frame with a colour chosen
//   by the location, then draws a fixed activity box coloured by the activity
//   (no box for activity 0). One pixel is emitted per clock.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   resetn      in   synchronous active-low reset
//   transition  in   high the cycle before location/activity change
//   location    in   [3:0] current location nibble
//   activity    in   [3:0] current activity nibble
//   x           out  [7:0] pixel column
//   y           out  [6:0] pixel row
//   colour      out  [2:0] pixel RGB
//   plot        out  pixel write-enable, x/y/colour valid when high
//   busy        out  high while a repaint is in progress (LOAD + drawing)
//   done        out  one-cycle pulse when a repaint completes
// -----------------------------------------------------------------------------
module scene_drawer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int BOX_X  = 72,
    parameter int BOX_Y  = 52,
    parameter int BOX_W  = 16,
    parameter int BOX_H  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       transition,
    input  logic [3:0] location,
    input  logic [3:0] activity,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
    localparam logic [7:0] BX_FIRST = 8'(BOX_X);
    localparam logic [7:0] BX_LAST  = 8'(BOX_X + BOX_W - 1);
    localparam logic [6:0] BY_FIRST = 7'(BOX_Y);
    localparam logic [6:0] BY_LAST  = 7'(BOX_Y + BOX_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_BOX,
        S_DONE
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_x, w_x_next;
    logic [6:0] r_y, w_y_next;
    logic [2:0] r_colour, w_colour_next;
    logic       r_plot, w_plot_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;
    logic [3:0] r_loc, w_loc_next;
    logic [3:0] r_act, w_act_next;

    function automatic logic [2:0] bg_colour(input logic [3:0] loc);
        case (loc)
            4'd0:    bg_colour = 3'b000;
            4'd1:    bg_colour = 3'b010;
            4'd2:    bg_colour = 3'b001;
            default: bg_colour = 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] fg_colour(input logic [3:0] act);
        case (act)
            4'd1:    fg_colour = 3'b110;
            4'd2:    fg_colour = 3'b101;
            default: fg_colour = 3'b100;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_loc    <= '0;
            r_act    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_loc    <= w_loc_next;
            r_act    <= w_act_next;
        end
    end

    // r_x/r_y always hold the pixel currently presented on the port, so the
    // "last pixel" tests below look at the registered coordinate and the
    // outputs of the next state are computed alongside the state itself.
    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;
        w_loc_next    = r_loc;
        w_act_next    = r_act;

        case (r_state)
            S_IDLE: begin
                if (transition) begin
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end
            end

            S_LOAD: begin
                if (transition) begin
                    // Another transition restarts the load cycle.
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end else begin
                    // Navigation has already applied the new nibbles here.
                    w_loc_next    = location;
                    w_act_next    = activity;
                    w_state_next  = S_CLEAR;
                    w_x_next      = '0;
                    w_y_next      = '0;
                    w_colour_next = bg_colour(location);
                    w_plot_next   = 1'b1;
                    w_busy_next   = 1'b1;
                end
            end

            S_CLEAR: begin
                if (transition) begin
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end else if (r_x >= X_LAST) begin
                    if (r_y >= Y_LAST) begin
                        if (r_act != 4'd0) begin
                            w_state_next  = S_BOX;
                            w_x_next      = BX_FIRST;
                            w_y_next      = BY_FIRST;
                            w_colour_next = fg_colour(r_act);
                            w_plot_next   = 1'b1;
                            w_busy_next   = 1'b1;
                        end else begin
                            w_state_next = S_DONE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_x_next    = '0;
                        w_y_next    = r_y + 7'd1;
                        w_plot_next = 1'b1;
                        w_busy_next = 1'b1;
                    end
                end else begin
                    w_x_next    = r_x + 8'd1;
                    w_plot_next = 1'b1;
                    w_busy_next = 1'b1;
                end
            end

            S_BOX: begin
                if (transition) begin
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end else if (r_x >= BX_LAST) begin
                    if (r_y >= BY_LAST) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_x_next    = BX_FIRST;
                        w_y_next    = r_y + 7'd1;
                        w_plot_next = 1'b1;
                        w_busy_next = 1'b1;
                    end
                end else begin
                    w_x_next    = r_x + 8'd1;
                    w_plot_next = 1'b1;
                    w_busy_next = 1'b1;
                end
            end

            S_DONE: begin
                // The done pulse is already on the port; a transition here
                // chains straight into the next repaint.
                if (transition) begin
                    w_state_next = S_LOAD;
                    w_busy_next  = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
